time_set_ctrl: RTL and testbench

//  Mode/sequencing controller for the clock's BCD time-counter chain. Gates the 1 Hz
//  run tick and, in set-time mode, walks a digit pointer (secU..hrT) and issues one-hot
//  per-digit increment pulses, with hold-to-auto-repeat. Drives the display blank mask
//  for the selected digit. Sits between the debouncers and the time counters/7-seg decode.

---
 rtl/time_set_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Mode/sequencing controller for the clock's BCD time-counter chain.
//   In RUN the 1 Hz tick is passed through to the counters. In set-time mode
//   a digit pointer (0=secU .. 5=hrT) selects which digit receives one-hot
//   increment pulses; holding the increment button auto-repeats. The selected
//   digit blinks on the display through blank_mask.
//
// Ports
//   clk           in   system clock, all logic on posedge
//   reset         in   synchronous, active-high
//   set_time      in   debounced level, 1 = set-time mode requested
//   select_pulse  in   single-cycle pulse, advance digit pointer
//   incr_level    in   debounced level of the increment button
//   tick_1hz      in   single-cycle 1 Hz tick
//   run_en        out  count enable to counter chain (tick gated by RUN)
//   digit_inc     out  one-hot single-cycle increment to the selected digit
//   sel_digit     out  current digit pointer
//   blank_mask    out  1 = blank that digit on the display
//   set_done      out  single-cycle pulse on leaving set mode
//   state_dbg     out  FSM state: 0=RUN 1=SET_IDLE 2=SET_HOLD 3=SET_REPEAT 4=EXIT
//
// Handshake: there is no back-pressure. digit_inc and set_done are
// single-cycle strobes that the consumer must accept on the cycle they are
// high; select_pulse and tick_1hz are consumed on the cycle they are high.
module time_set_ctrl #(
  parameter int NUM_DIGITS    = 6,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10,
  parameter int BLINK_HALF    = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_time,
  input  logic                  select_pulse,
  input  logic                  incr_level,
  input  logic                  tick_1hz,
  output logic                  run_en,
  output logic [NUM_DIGITS-1:0] digit_inc,
  output logic [2:0]            sel_digit,
  output logic [NUM_DIGITS-1:0] blank_mask,
  output logic                  set_done,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_IDLE   = 3'd1,
    SET_HOLD   = 3'd2,
    SET_REPEAT = 3'd3,
    EXIT       = 3'd4
  } state_t;

  localparam int HW = $clog2(REPEAT_DELAY);
  localparam int RW = $clog2(REPEAT_PERIOD);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  // Hold counter is cleared on the first pulse and fires when its next
  // value would reach REPEAT_DELAY-1, giving REPEAT_DELAY held samples
  // (first pulse included) before the first auto-repeat.
  localparam logic [HW-1:0] HOLD_LAST  = HW'(REPEAT_DELAY - 2);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [2:0]    SEL_LAST   = 3'(NUM_DIGITS - 1);

  state_t          state, state_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [RW-1:0]   rep_cnt, rep_n;
  logic [BW-1:0]   blink_cnt, blink_n;
  logic            phase, phase_n;
  logic [2:0]      sel_n;
  logic            incr_q;
  logic            incr_rise;
  logic            fire;
  logic            in_set_n;

  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [2:0] s);
    onehot = NUM_DIGITS'(1) << s;
  endfunction

  assign incr_rise = incr_level & ~incr_q;
  assign run_en    = tick_1hz & (state == RUN);
  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    sel_n    = sel_digit;
    hold_n   = hold_cnt;
    rep_n    = rep_cnt;
    blink_n  = blink_cnt;
    phase_n  = phase;
    fire     = 1'b0;
    unique case (state)
      RUN: begin
        if (set_time) begin
          state_n = SET_IDLE;
          sel_n   = '0;
          phase_n = 1'b1;
          blink_n = '0;
        end
      end
      EXIT: state_n = RUN;
      default: begin
        // Leaving set mode wins over increment and select.
        if (!set_time) begin
          state_n = EXIT;
        end else begin
          if (blink_cnt == BLINK_LAST) begin
            blink_n = '0;
            phase_n = ~phase;
          end else begin
            blink_n = blink_cnt + 1'b1;
          end
          unique case (state)
            SET_IDLE: begin
              if (incr_rise) begin
                fire    = 1'b1;
                hold_n  = '0;
                state_n = SET_HOLD;
              end
            end
            SET_HOLD: begin
              if (!incr_level) begin
                state_n = SET_IDLE;
              end else if (hold_cnt == HOLD_LAST) begin
                fire    = 1'b1;
                rep_n   = '0;
                state_n = SET_REPEAT;
              end else begin
                hold_n = hold_cnt + 1'b1;
              end
            end
            default: begin
              if (!incr_level) begin
                state_n = SET_IDLE;
              end else if (rep_cnt == REP_LAST) begin
                fire  = 1'b1;
                rep_n = '0;
              end else begin
                rep_n = rep_cnt + 1'b1;
              end
            end
          endcase
          // A pointer move always needs a fresh press before incrementing
          // again; a same-edge pulse still targets the old pointer.
          if (select_pulse) begin
            sel_n   = (sel_digit == SEL_LAST) ? 3'd0 : sel_digit + 3'd1;
            state_n = SET_IDLE;
          end
          if (fire || select_pulse) begin
            phase_n = 1'b1;
            blink_n = '0;
          end
        end
      end
    endcase
    in_set_n = (state_n == SET_IDLE) || (state_n == SET_HOLD) || (state_n == SET_REPEAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      sel_digit  <= '0;
      hold_cnt   <= '0;
      rep_cnt    <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      incr_q     <= 1'b0;
      digit_inc  <= '0;
      blank_mask <= '0;
      set_done   <= 1'b0;
    end else begin
      state      <= state_n;
      sel_digit  <= sel_n;
      hold_cnt   <= hold_n;
      rep_cnt    <= rep_n;
      blink_cnt  <= blink_n;
      phase      <= phase_n;
      incr_q     <= incr_level;
      digit_inc  <= fire ? onehot(sel_digit) : '0;
      blank_mask <= (in_set_n && !phase_n) ? onehot(sel_n) : '0;
      set_done   <= (state_n == EXIT);
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl
//   Directed bench for time_set_ctrl with default parameters. Expected
//   digit_inc pulses ({edge index, one-hot value}) and set_done pulses
//   (edge index) are queued by the driver; a negedge monitor pops and
//   compares whenever the DUT raises either strobe.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_time;
  logic       select_pulse;
  logic       incr_level;
  logic       tick_1hz;
  logic       run_en;
  logic [5:0] digit_inc;
  logic [2:0] sel_digit;
  logic [5:0] blank_mask;
  logic       set_done;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [37:0] exp_q[$];
  logic [31:0] done_q[$];

  time_set_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .set_time     (set_time),
    .select_pulse (select_pulse),
    .incr_level   (incr_level),
    .tick_1hz     (tick_1hz),
    .run_en       (run_en),
    .digit_inc    (digit_inc),
    .sel_digit    (sel_digit),
    .blank_mask   (blank_mask),
    .set_done     (set_done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, cyc);
  endtask

  // Advance n edges; inputs changed afterwards are sampled at edge cyc+1.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pulse(input int c, input logic [5:0] v);
    exp_q.push_back({32'(c), v});
  endtask

  task automatic select_once();
    select_pulse = 1'b1;
    step(1);
    select_pulse = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [37:0] e;
    if (digit_inc != 6'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", digit_inc, 6'b0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge", cyc, e[37:6]);
        check("pulse_value", digit_inc, e[5:0]);
      end
    end
    if (set_done) begin
      if (done_q.size() == 0) check("unexpected_set_done", set_done, 1'b0);
      else check("set_done_edge", cyc, done_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0] walk [7];
  int base;

  initial begin
    walk = '{3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    reset = 1'b1; set_time = 1'b0; select_pulse = 1'b0;
    incr_level = 1'b0; tick_1hz = 1'b0;
    step(3);
    check("rst_state", state_dbg, 3'd0);
    check("rst_sel", sel_digit, 3'd0);
    check("rst_blank", blank_mask, 6'b0);
    reset = 1'b0;
    step(1);

    // Run mode: ticks pass through as run_en.
    for (int i = 0; i < 3; i++) begin
      step(99);
      tick_1hz = 1'b1;
      #1;
      check("run_en_tick", run_en, 1'b1);
      step(1);
      tick_1hz = 1'b0;
      #1;
      check("run_en_idle", run_en, 1'b0);
    end

    // Enter set mode; selected digit blinks after BLINK_HALF cycles.
    set_time = 1'b1;
    step(1);
    check("set_state", state_dbg, 3'd1);
    check("set_sel0", sel_digit, 3'd0);
    step(24);
    check("blink_visible", blank_mask, 6'b000000);
    step(1);
    check("blink_blank", blank_mask, 6'b000001);
    tick_1hz = 1'b1;
    #1;
    check("run_en_gated", run_en, 1'b0);
    step(1);
    tick_1hz = 1'b0;

    // Two selects, then three short presses on digit 2.
    select_once();
    check("sel_1", sel_digit, 3'd1);
    check("sel_visible", blank_mask, 6'b0);
    select_once();
    check("sel_2", sel_digit, 3'd2);
    for (int i = 0; i < 3; i++) begin
      incr_level = 1'b1;
      push_pulse(cyc + 1, 6'b000100);
      step(5);
      incr_level = 1'b0;
      step(3);
    end
    check("short_press_done", exp_q.size(), 0);

    // Held 99 sampled edges: first pulse, repeat after 50, then every 10.
    base = cyc;
    incr_level = 1'b1;
    push_pulse(base + 1,  6'b000100);
    push_pulse(base + 50, 6'b000100);
    push_pulse(base + 60, 6'b000100);
    push_pulse(base + 70, 6'b000100);
    push_pulse(base + 80, 6'b000100);
    push_pulse(base + 90, 6'b000100);
    step(99);
    incr_level = 1'b0;
    step(5);
    check("repeat_done", exp_q.size(), 0);

    // Pointer walk with wrap 5->0, ending on 3.
    for (int i = 0; i < 7; i++) begin
      select_once();
      check("walk_sel", sel_digit, walk[i]);
    end
    // Same-edge rise and select: pulse to old digit 3, pointer to 4.
    incr_level = 1'b1;
    select_pulse = 1'b1;
    push_pulse(cyc + 1, 6'b001000);
    step(1);
    select_pulse = 1'b0;
    check("same_edge_sel", sel_digit, 3'd4);
    step(3);
    incr_level = 1'b0;
    step(2);
    check("same_edge_done", exp_q.size(), 0);

    // Exit on the edge where the first auto-repeat would fire.
    base = cyc;
    incr_level = 1'b1;
    push_pulse(base + 1, 6'b010000);
    step(49);
    set_time = 1'b0;
    done_q.push_back(32'(base + 50));
    step(1);
    check("exit_state", state_dbg, 3'd4);
    check("exit_no_pulse", digit_inc, 6'b0);
    check("exit_blank", blank_mask, 6'b0);
    step(1);
    check("exit_to_run", state_dbg, 3'd0);
    check("run_sel_hold", sel_digit, 3'd4);
    incr_level = 1'b0;
    step(2);
    check("exit_queues", exp_q.size() + done_q.size(), 0);

    // Reset while auto-repeating on digit 1.
    set_time = 1'b1;
    step(1);
    select_once();
    base = cyc;
    incr_level = 1'b1;
    push_pulse(base + 1,  6'b000010);
    push_pulse(base + 50, 6'b000010);
    push_pulse(base + 60, 6'b000010);
    step(62);
    check("pre_reset_state", state_dbg, 3'd3);
    reset = 1'b1;
    step(1);
    check("mid_rst_state", state_dbg, 3'd0);
    check("mid_rst_sel", sel_digit, 3'd0);
    check("mid_rst_inc", digit_inc, 6'b0);
    check("mid_rst_blank", blank_mask, 6'b0);
    check("mid_rst_done", set_done, 1'b0);
    step(2);
    incr_level = 1'b0;
    set_time = 1'b0;
    reset = 1'b0;
    step(3);
    check("post_rst_state", state_dbg, 3'd0);
    check("final_queues", exp_q.size() + done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
